// File: rtl/cycloneive_arb_pkg.sv
// Shared types and constants for the 4-way round-robin mux arbiter.
package cycloneive_arb_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/cycloneive_rr_pick.sv
// Rotate-priority picker: first requester at or after ptr, wrapping mod 4.
module cycloneive_rr_pick
    import cycloneive_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [1:0]         winner,
    output logic               any
);

    logic [1:0] idx;

    // Scan from the farthest offset down so the nearest requester to ptr wins.
    always_comb begin
        winner = ptr;
        any    = 1'b0;
        idx    = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cycloneive_mux41_arbiter.sv
// Round-robin arbiter driving the select of an external 4:1 mux.
// Grants are held until done, req drop, or MAX_HOLD cycles, then a
// one-cycle RELEASE gap advances the pointer past the last winner.
//
// state   | meaning
// IDLE    | no grant; pick a winner when any req is high
// GRANT   | gnt[S] asserted, hold counter running
// RELEASE | one dead cycle, ptr moves past the winner
module cycloneive_mux41_arbiter
    import cycloneive_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [1:0]         S,
    output logic               gnt_valid,
    output logic               timeout
);

    localparam int HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    arb_state_e         state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [1:0]         s_q, s_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic               timeout_q, timeout_d;

    logic [1:0] winner;
    logic       any;
    logic       done_w, req_w, at_limit;

    cycloneive_rr_pick u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (winner),
        .any    (any)
    );

    // Only the current winner's done/req bits matter while granted.
    assign done_w   = done[s_q];
    assign req_w    = req[s_q];
    assign at_limit = (hold_q == HOLD_LAST);

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        gnt_d       = gnt_q;
        s_d         = s_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any) begin
                    state_d     = GRANT;
                    s_d         = winner;
                    gnt_d       = NUM_REQ'(1) << winner;
                    gnt_valid_d = 1'b1;
                    hold_d      = '0;
                end
            end
            GRANT: begin
                if (done_w || !req_w || at_limit) begin
                    state_d     = RELEASE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    hold_d      = '0;
                    // A cooperative release on the limit cycle is not a timeout.
                    timeout_d   = at_limit && !done_w && req_w;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            RELEASE: begin
                ptr_d   = s_q + 2'd1;
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            hold_q      <= '0;
            gnt_q       <= '0;
            s_q         <= 2'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
            gnt_q       <= gnt_d;
            s_q         <= s_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign S         = s_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule
